// File: rtl/bcd_pkg.sv
// Shared types, constants and helpers for the serial BCD-to-binary converter.
// Sized for up to 38 decimal digits in the width helper.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam int unsigned BCD_MAX         = 9;
  localparam int unsigned BCD_INVALID_SUB = 0;
  localparam int unsigned BCD_MAX_DIGITS  = 38;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } bcd_state_t;

  // Smallest binary width that holds 10**n - 1, i.e. ceil(n*log2(10)).
  function automatic int unsigned bcd_bin_w(input int unsigned n);
    logic [127:0] pow10;
    int unsigned  w;
    pow10 = 128'd1;
    w     = 0;
    for (int unsigned i = 0; i < BCD_MAX_DIGITS; i++) begin
      if (i < n) pow10 = pow10 * 128'd10;
    end
    for (int unsigned i = 0; i < 128; i++) begin
      if ((128'd1 << i) < pow10) w = i + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/bcd_serial_to_binary_if.sv
// Digit-in / result-out handshake bundle for bcd_serial_to_binary.
// master drives digits and consumes results; slave is the converter.
interface bcd_serial_to_binary_if
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W = 54,
  parameter int unsigned CNT_W = 5
) ();

  logic             digit_valid;
  logic             digit_ready;
  bcd_digit_t       bcd_digit;
  logic             digit_last;

  logic             bin_valid;
  logic             bin_ready;
  logic [BIN_W-1:0] bin_value;
  logic [CNT_W-1:0] bin_count;
  logic             bin_error;

  modport master (
    output digit_valid, bcd_digit, digit_last, bin_ready,
    input  digit_ready, bin_valid, bin_value, bin_count, bin_error
  );

  modport slave (
    input  digit_valid, bcd_digit, digit_last, bin_ready,
    output digit_ready, bin_valid, bin_value, bin_count, bin_error
  );

endinterface

// File: rtl/bcd_mac10.sv
// Combinational acc*10 + digit step; digits above 9 contribute the substitute
// value and raise invalid_c so the caller can track a sticky error.
module bcd_mac10
  import bcd_pkg::*;
#(
  parameter int unsigned W = 54
) (
  input  logic [W-1:0] acc,
  input  bcd_digit_t   digit,
  output logic [W-1:0] mac_c,
  output logic         invalid_c
);

  bcd_digit_t digit_eff;

  // x*10 as (x<<3)+(x<<1), wrapping at W bits.
  always_comb begin
    invalid_c = (digit > 4'(BCD_MAX));
    digit_eff = invalid_c ? 4'(BCD_INVALID_SUB) : digit;
    mac_c     = (acc << 3) + (acc << 1) + W'(digit_eff);
  end

endmodule

// File: rtl/bcd_serial_to_binary.sv
// Accumulates a most-significant-first BCD digit stream into an unsigned binary
// result, then holds it on a valid/ready output until consumed.
module bcd_serial_to_binary
  import bcd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 16,
  parameter int unsigned BIN_W      = bcd_bin_w(NUM_DIGITS),
  parameter int unsigned CNT_W      = $clog2(NUM_DIGITS + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  bcd_serial_to_binary_if.slave  bus
);

  bcd_state_t       state;
  logic [BIN_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             err;

  logic             digit_ready_q;
  logic             bin_valid_q;
  logic [BIN_W-1:0] bin_value_q;
  logic [CNT_W-1:0] bin_count_q;
  logic             bin_error_q;

  logic [BIN_W-1:0] acc_nxt_c;
  logic [CNT_W-1:0] count_nxt_c;
  logic             digit_bad_c;
  logic             err_nxt_c;
  logic             accept_c;
  logic             terminate_c;
  logic             consume_c;

  bcd_mac10 #(.W(BIN_W)) u_mac10 (
    .acc       (acc),
    .digit     (bus.bcd_digit),
    .mac_c     (acc_nxt_c),
    .invalid_c (digit_bad_c)
  );

  // Handshake qualifiers; the NUM_DIGITS-th digit closes the number on its own.
  always_comb begin
    accept_c    = bus.digit_valid && digit_ready_q;
    consume_c   = bin_valid_q && bus.bin_ready;
    count_nxt_c = CNT_W'(count + CNT_W'(1));
    err_nxt_c   = err || digit_bad_c;
    terminate_c = bus.digit_last || (count == CNT_W'(NUM_DIGITS - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ACCUM;
      acc           <= '0;
      count         <= '0;
      err           <= 1'b0;
      digit_ready_q <= 1'b1;
      bin_valid_q   <= 1'b0;
      bin_value_q   <= '0;
      bin_count_q   <= '0;
      bin_error_q   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept_c) begin
            acc   <= acc_nxt_c;
            count <= count_nxt_c;
            err   <= err_nxt_c;
            if (terminate_c) begin
              // Publish the result including the terminating digit.
              state         <= HOLD;
              digit_ready_q <= 1'b0;
              bin_valid_q   <= 1'b1;
              bin_value_q   <= acc_nxt_c;
              bin_count_q   <= count_nxt_c;
              bin_error_q   <= err_nxt_c;
            end
          end
        end
        HOLD: begin
          if (consume_c) begin
            state         <= ACCUM;
            acc           <= '0;
            count         <= '0;
            err           <= 1'b0;
            digit_ready_q <= 1'b1;
            bin_valid_q   <= 1'b0;
            bin_value_q   <= '0;
            bin_count_q   <= '0;
            bin_error_q   <= 1'b0;
          end
        end
        default: begin
          state         <= ACCUM;
          digit_ready_q <= 1'b1;
          bin_valid_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.digit_ready = digit_ready_q;
  assign bus.bin_valid   = bin_valid_q;
  assign bus.bin_value   = bin_value_q;
  assign bus.bin_count   = bin_count_q;
  assign bus.bin_error   = bin_error_q;

endmodule

// File: tb/tb_bcd_serial_to_binary.sv
// Randomised bench for bcd_serial_to_binary against a digit-queue decimal model,
// with directed numbers pinning known results.
module tb_bcd_serial_to_binary;

  localparam int unsigned NUM_DIGITS = 16;
  localparam int unsigned BIN_W      = 54;
  localparam int unsigned CNT_W      = 5;

  logic clk;
  logic reset;

  bcd_serial_to_binary_if #(.BIN_W(BIN_W), .CNT_W(CNT_W)) bus ();

  bcd_serial_to_binary #(
    .NUM_DIGITS (NUM_DIGITS),
    .BIN_W      (BIN_W),
    .CNT_W      (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int ready_pct   = 100;
  int numbers_sent = 0;
  int consumed    = 0;

  // Reference: the digits accepted for the current number, and whether it is held.
  int q_digits[$];
  bit m_hold = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_value();
    logic [63:0] v;
    v = 64'd0;
    foreach (q_digits[i]) v = v * 64'd10 + ((q_digits[i] > 9) ? 64'd0 : 64'(q_digits[i]));
    return 64'(BIN_W'(v));
  endfunction

  function automatic logic model_error();
    logic e;
    e = 1'b0;
    foreach (q_digits[i]) if (q_digits[i] > 9) e = 1'b1;
    return e;
  endfunction

  // Consumer readiness, re-drawn each cycle.
  initial begin
    bus.bin_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1 bus.bin_ready = ($urandom_range(99) < ready_pct);
    end
  end

  // Cycle compare against the model, then advance the model for the coming edge.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_ready", 64'(bus.digit_ready), 64'd1);
        chk("rst_valid", 64'(bus.bin_valid), 64'd0);
        chk("rst_value", 64'(bus.bin_value), 64'd0);
        chk("rst_count", 64'(bus.bin_count), 64'd0);
        chk("rst_error", 64'(bus.bin_error), 64'd0);
        q_digits.delete();
        m_hold = 1'b0;
      end else begin
        chk("digit_ready", 64'(bus.digit_ready), 64'(!m_hold));
        chk("bin_valid", 64'(bus.bin_valid), 64'(m_hold));
        chk("bin_value", 64'(bus.bin_value), m_hold ? model_value() : 64'd0);
        chk("bin_count", 64'(bus.bin_count), m_hold ? 64'(q_digits.size()) : 64'd0);
        chk("bin_error", 64'(bus.bin_error), m_hold ? 64'(model_error()) : 64'd0);
        if (!m_hold && bus.digit_valid) begin
          q_digits.push_back(int'(bus.bcd_digit));
          if (bus.digit_last || q_digits.size() == NUM_DIGITS) m_hold = 1'b1;
        end else if (m_hold && bus.bin_ready) begin
          m_hold = 1'b0;
          q_digits.delete();
          consumed++;
        end
      end
    end
  end

  // Present one digit after gap idle cycles and hold it until accepted.
  task automatic send_digit(input logic [3:0] d, input logic last, input int gap);
    bit done;
    bit rdy;
    done = 1'b0;
    bus.digit_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus.digit_valid = 1'b1;
    bus.bcd_digit   = d;
    bus.digit_last  = last;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      rdy = bus.digit_ready;
      @(posedge clk);
      #1;
      done = rdy;
    end
    if (!done) chk("send_timeout", 64'd0, 64'd1);
    bus.digit_valid = 1'b0;
    bus.bcd_digit   = 4'd0;
    bus.digit_last  = 1'b0;
  endtask

  // Literal expectation on the next presented result; lat bounds negedges waited.
  task automatic wait_result(input string name, input logic [63:0] val, input int cnt,
                             input logic err, input int lat);
    int waited;
    bit seen;
    seen   = 1'b0;
    waited = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.bin_valid) seen = 1'b1;
      else waited++;
    end
    chk({name, "_seen"}, 64'(seen), 64'd1);
    chk({name, "_lat"}, 64'(waited <= lat), 64'd1);
    chk({name, "_value"}, 64'(bus.bin_value), val);
    chk({name, "_count"}, 64'(bus.bin_count), 64'(cnt));
    chk({name, "_error"}, 64'(bus.bin_error), 64'(err));
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    int len;
    bit forced;
    logic [3:0] d;
    reset = 1'b1;
    bus.digit_valid = 1'b0;
    bus.bcd_digit   = 4'd0;
    bus.digit_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    ready_pct = 100;

    // 1234, result the cycle after the last digit.
    send_digit(4'd1, 1'b0, 0);
    send_digit(4'd2, 1'b0, 0);
    send_digit(4'd3, 1'b0, 0);
    send_digit(4'd4, 1'b1, 0);
    wait_result("n1234", 64'd1234, 4, 1'b0, 0);
    numbers_sent++;

    // Sixteen 9s without digit_last: forced termination.
    for (int k = 0; k < 16; k++) send_digit(4'd9, 1'b0, 0);
    wait_result("n16x9", 64'd9999999999999999, 16, 1'b0, 0);
    numbers_sent++;

    // Invalid digit substitutes 0 and flags; the flag clears for the next number.
    send_digit(4'd5, 1'b0, 0);
    send_digit(4'hC, 1'b0, 0);
    send_digit(4'd7, 1'b1, 0);
    wait_result("n507", 64'd507, 3, 1'b1, 0);
    numbers_sent++;
    send_digit(4'd8, 1'b1, 0);
    wait_result("n8", 64'd8, 1, 1'b0, 0);
    numbers_sent++;

    // 42 held under back-pressure while a further digit waits.
    send_digit(4'd4, 1'b0, 1);
    ready_pct = 0;
    send_digit(4'd2, 1'b1, 0);
    wait_result("n42", 64'd42, 2, 1'b0, 0);
    numbers_sent++;
    fork
      send_digit(4'd6, 1'b1, 0);
      begin
        repeat (5) begin
          @(negedge clk);
          chk("hold_ready", 64'(bus.digit_ready), 64'd0);
          chk("hold_value", 64'(bus.bin_value), 64'd42);
          chk("hold_count", 64'(bus.bin_count), 64'd2);
        end
        ready_pct = 100;
      end
    join
    wait_result("n6", 64'd6, 1, 1'b0, 0);
    numbers_sent++;

    // Reset mid-number discards the partial 77.
    send_digit(4'd7, 1'b0, 0);
    send_digit(4'd7, 1'b0, 0);
    do_reset(2);
    chk("post_rst_valid", 64'(bus.bin_valid), 64'd0);
    chk("post_rst_value", 64'(bus.bin_value), 64'd0);
    send_digit(4'd3, 1'b1, 0);
    wait_result("n3", 64'd3, 1, 1'b0, 0);
    numbers_sent++;

    // Random numbers, gaps and back-pressure.
    ready_pct = 70;
    for (int n = 0; n < 60; n++) begin
      len    = $urandom_range(16, 1);
      forced = (len == 16) && ($urandom_range(1) == 1);
      for (int k = 0; k < len; k++) begin
        d = ($urandom_range(19) == 0) ? 4'($urandom_range(15, 10)) : 4'($urandom_range(9));
        send_digit(d, (k == len - 1) && !forced, ($urandom_range(3) == 0) ? $urandom_range(2, 1) : 0);
      end
      numbers_sent++;
    end

    ready_pct = 100;
    for (int i = 0; i < 50 && (m_hold || bus.bin_valid); i++) @(posedge clk);
    repeat (2) @(negedge clk);
    chk("drained", 64'(bus.bin_valid), 64'd0);
    chk("results_consumed", 64'(consumed), 64'(numbers_sent));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_serial_to_binary.md
BCD_SERIAL_TO_BINARY -- requirements
Module: bcd_serial_to_binary

Interface
REQ-001 Parameter NUM_DIGITS, default 16, maximum BCD digits per number.
REQ-002 Parameter BIN_W, default 54, binary result width; SHALL satisfy BIN_W >= ceil(NUM_DIGITS*log2(10)).
REQ-003 Parameter CNT_W, default $clog2(NUM_DIGITS+1), digit-count width.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 digit_valid  input  1  bcd_digit/digit_last valid this cycle.
REQ-007 digit_ready  output  1  block accepts a digit this cycle.
REQ-008 bcd_digit  input  4  one BCD digit, most-significant digit first.
REQ-009 digit_last  input  1  accompanying digit is the final (least-significant) digit.
REQ-010 bin_valid  output  1  result available.
REQ-011 bin_ready  input  1  consumer takes result.
REQ-012 bin_value  output  BIN_W  unsigned binary value of accepted digit string.
REQ-013 bin_count  output  CNT_W  number of digits in the result (1..NUM_DIGITS).
REQ-014 bin_error  output  1  at least one digit in the result was > 9.

Function
REQ-015 States ACCUM and HOLD only; reset state ACCUM.
REQ-016 ACCUM: digit_ready=1, bin_valid=0; HOLD: digit_ready=0, bin_valid=1.
REQ-017 Digit accepted iff digit_valid && digit_ready on a rising edge.
REQ-018 On accept: acc <= (acc<<3)+(acc<<1)+d, truncated to BIN_W bits; d = bcd_digit if <= 9, else 0.
REQ-019 On accept of digit > 9: error flag set, sticky until the result is consumed.
REQ-020 On accept: count <= count+1.
REQ-021 Transition ACCUM->HOLD on accept with digit_last=1, or on accept of the NUM_DIGITS-th digit regardless of digit_last.
REQ-022 Latency: bin_valid asserts the cycle after the terminating digit is accepted; bin_value includes that digit.
REQ-023 In HOLD, bin_value, bin_count and bin_error SHALL be stable until the handshake completes.
REQ-024 HOLD->ACCUM on bin_valid && bin_ready; same edge clears acc, count and error to 0.
REQ-025 digit_valid is ignored in HOLD; no digit is accepted in the cycle in which the result is consumed.
REQ-026 digit_valid=0 in ACCUM holds all state; gaps between digits are allowed.
REQ-027 In ACCUM, bin_value/bin_count/bin_error outputs are driven to 0.
REQ-028 Leading zeros are counted in bin_count and do not change the value.
REQ-029 Sustained throughput: one digit per cycle in ACCUM; one idle cycle per number for the HOLD handshake minimum.

Reset
REQ-030 reset asserted: state=ACCUM, acc=0, count=0, error=0, digit_ready=1, bin_valid=0, bin_value=0, bin_count=0, bin_error=0.
REQ-031 Reset mid-number or in HOLD discards the partial or held result; no output pulse follows.
REQ-032 Reset release is synchronous to clk; the first digit can be accepted on the first edge after deassertion.

Structure
REQ-033 Shared package bcd_pkg holds: bcd_digit_t (4-bit typedef), BCD_MAX=9, BCD_INVALID_SUB=0, and bin-width helper function bcd_bin_w(n).
REQ-034 One combinational sub-module bcd_mac10 (acc*10 + digit, width-parameterised); all state stays in the top module.

Verification
REQ-035 Digits 1,2,3,4 (last on 4), bin_ready=1 -> bin_value=1234, bin_count=4, bin_error=0, bin_valid one cycle after digit 4.
REQ-036 Sixteen 9s, digit_last=0 throughout -> forced termination, bin_value=9999999999999999, bin_count=16.
REQ-037 Digits 5,0xC,7 (last) -> bin_value=507, bin_error=1; the next number 8 (last) -> bin_value=8, bin_error=0.
REQ-038 Number 42 then bin_ready=0 for 5 cycles while digit_valid=1 -> outputs stable, digit_ready=0, no digit consumed; then bin_ready=1 -> next digit is accepted the following cycle.
REQ-039 Reset asserted after digits 7,7 -> all outputs 0; then 3 (last) -> bin_value=3, bin_count=1.
REQ-040 Random digit_valid gaps with random numbers of 1..16 digits -> results match a decimal reference model.
